// File: rtl/exec_cycle_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for a tiny ADD/ADDI/SUB core.
// Every output is either a register or a decode of the registered state.
module exec_cycle_ctrl #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop_req,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  output logic [31:0]         instr,
  output logic                alu_en,
  output logic [2:0]          exec_op,
  output logic                reg_we,
  output logic                wb_sel,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic                fetch_err,
  output logic [15:0]         retired
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam int            TW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  logic [2:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [2:0]          op_q, op_d;
  logic                wb_q, wb_d;
  logic                ill_q, ill_d;
  logic                ferr_q, ferr_d;
  logic [15:0]         ret_q, ret_d;
  logic [TW-1:0]       cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    op_d    = op_q;
    wb_d    = wb_q;
    ill_d   = ill_q;
    ferr_d  = ferr_q;
    ret_d   = ret_q;
    // Counter idles at zero outside FETCH, so every FETCH entry starts fresh.
    cnt_d   = '0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = S_DEC;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) begin
            state_d = S_HALT;
            ferr_d  = 1'b1;
          end
        end
      end
      S_DEC: begin
        case (instr_q[31:26])
          6'b000000: begin op_d = 3'b001; wb_d = 1'b0; state_d = S_EXEC; end
          6'b001000: begin op_d = 3'b010; wb_d = 1'b1; state_d = S_EXEC; end
          6'b000010: begin op_d = 3'b011; wb_d = 1'b0; state_d = S_EXEC; end
          6'b111111: state_d = S_HALT;
          default: begin
            op_d    = 3'b000;
            ill_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        pc_d = pc_q + PC_WIDTH'(4);
        if (ret_q != 16'hFFFF) ret_d = ret_q + 16'd1;
        state_d = stop_req ? S_IDLE : S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = PC_WIDTH'(RESET_PC);
          ill_d   = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC_WIDTH'(RESET_PC);
      instr_q <= '0;
      op_q    <= '0;
      wb_q    <= 1'b0;
      ill_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ret_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      op_q    <= op_d;
      wb_q    <= wb_d;
      ill_q   <= ill_d;
      ferr_q  <= ferr_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign alu_en    = (state_q == S_EXEC);
  assign reg_we    = (state_q == S_WB);
  assign busy      = (state_q == S_FETCH) || (state_q == S_DEC) ||
                     (state_q == S_EXEC)  || (state_q == S_WB);
  assign halted    = (state_q == S_HALT);
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign exec_op   = op_q;
  assign wb_sel    = wb_q;
  assign illegal   = ill_q;
  assign fetch_err = ferr_q;
  assign retired   = ret_q;

endmodule

// File: tb/tb_exec_cycle_ctrl.sv
// Directed bench for exec_cycle_ctrl: main 8-bit-PC instance plus a 4-bit-PC instance for wrap.
module tb_exec_cycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 0, stop_req = 0, imem_ack = 0;
  logic [31:0] imem_data = '0;
  logic        imem_req, alu_en, reg_we, wb_sel, busy, halted, illegal, fetch_err;
  logic [7:0]  imem_addr;
  logic [31:0] instr;
  logic [2:0]  exec_op;
  logic [15:0] retired;

  logic        start2 = 0, stop2 = 0;
  logic        req2, alu2, we2, wbs2, busy2, halt2, ill2, ferr2;
  logic [3:0]  addr2;
  logic [31:0] instr2;
  logic [2:0]  op2;
  logic [15:0] ret2;

  exec_cycle_ctrl #(.PC_WIDTH(8), .RESET_PC(0), .TIMEOUT(15)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_req(stop_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .alu_en(alu_en), .exec_op(exec_op), .reg_we(reg_we), .wb_sel(wb_sel),
    .busy(busy), .halted(halted), .illegal(illegal), .fetch_err(fetch_err), .retired(retired)
  );

  exec_cycle_ctrl #(.PC_WIDTH(4), .RESET_PC(0), .TIMEOUT(15)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop_req(stop2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(1'b1), .imem_data(32'h00221800),
    .instr(instr2), .alu_en(alu2), .exec_op(op2), .reg_we(we2), .wb_sel(wbs2),
    .busy(busy2), .halted(halt2), .illegal(ill2), .fetch_err(ferr2), .retired(ret2)
  );

  int n_chk = 0, n_err = 0;
  int we_cnt = 0, onehot_bad = 0;

  always @(negedge clk) begin
    if (reg_we) we_cnt++;
    if ((32'(imem_req) + 32'(alu_en) + 32'(reg_we)) > 1) onehot_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n, we0;

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_pc", imem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_ret", retired, 0);
    chk("rst_flags", {imem_req, alu_en, reg_we, halted, illegal, fetch_err, wb_sel}, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    chk("idle_wait", busy, 0);

    // Zero-wait ADD
    imem_data = 32'h00221800; imem_ack = 1; start = 1;
    tick(); start = 0;
    chk("add_fetch_req", imem_req, 1);
    chk("add_fetch_addr", imem_addr, 0);
    tick();
    chk("add_instr", instr, 32'h00221800);
    chk("add_dec_req", imem_req, 0);
    tick();
    chk("add_alu_en", alu_en, 1);
    chk("add_op", exec_op, 3'b001);
    chk("add_wbsel", wb_sel, 0);
    tick();
    chk("add_reg_we_c4", reg_we, 1);
    stop_req = 1;
    tick(); stop_req = 0;
    chk("add_pc", imem_addr, 4);
    chk("add_ret", retired, 1);
    chk("add_idle", busy, 0);

    // ADDI with ack after 3 wait cycles
    imem_data = 32'h20220005; imem_ack = 0; start = 1;
    tick(); start = 0;
    n = 0;
    while (imem_req && n < 20) begin
      n++;
      if (n == 4) imem_ack = 1;
      tick();
    end
    imem_ack = 0;
    chk("addi_req_cycles", n, 4);
    chk("addi_instr", instr, 32'h20220005);
    tick();
    chk("addi_op", exec_op, 3'b010);
    chk("addi_wbsel", wb_sel, 1);
    tick();
    chk("addi_we", reg_we, 1);
    stop_req = 1;
    tick(); stop_req = 0;
    chk("addi_pc", imem_addr, 8);
    chk("addi_ret", retired, 2);

    // Fetch timeout
    we0 = we_cnt; start = 1;
    tick(); start = 0;
    n = 0;
    while (imem_req && n < 40) begin n++; tick(); end
    chk("tmo_cycles", n, 15);
    chk("tmo_halted", halted, 1);
    chk("tmo_ferr", fetch_err, 1);
    chk("tmo_no_we", we_cnt - we0, 0);
    tick();
    chk("halt_stable", {halted, fetch_err, imem_addr}, {1'b1, 1'b1, 8'd8});
    imem_data = 32'h0C000000; imem_ack = 1; start = 1;
    tick(); start = 0;
    chk("restart_pc", imem_addr, 0);
    chk("restart_ferr", fetch_err, 0);
    tick(); tick();
    chk("ill_halted", halted, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_op", exec_op, 0);
    chk("ill_ret", retired, 2);

    // Clean halt opcode clears illegal via restart
    imem_data = 32'hFC000000; start = 1;
    tick(); start = 0;
    chk("hlt_restart_ill", illegal, 0);
    tick(); tick();
    chk("hlt_halted", halted, 1);
    chk("hlt_ill", illegal, 0);
    chk("hlt_ret", retired, 2);

    // Async reset during EXECUTE
    imem_data = 32'h00221800; start = 1;
    tick(); start = 0;
    tick(); tick();
    chk("rx_in_exec", alu_en, 1);
    we0 = we_cnt;
    #2 rst_n = 0;
    #1;
    chk("rx_async", {alu_en, busy, halted, imem_req, reg_we}, 0);
    chk("rx_ret", retired, 0);
    chk("rx_op", exec_op, 0);
    chk("rx_instr", instr, 0);
    tick();
    rst_n = 1;
    tick(); tick();
    chk("rx_no_we", we_cnt - we0, 0);
    chk("rx_idle", {busy, halted}, 0);

    // Timeout boundary: ack in the 15th FETCH cycle wins
    imem_ack = 0; start = 1;
    tick(); start = 0;
    for (int i = 1; i < 15; i++) tick();
    chk("bnd_still_fetch", imem_req, 1);
    imem_ack = 1;
    tick(); imem_ack = 0;
    chk("bnd_decode", {halted, fetch_err, busy, imem_req}, 4'b0010);
    tick();
    chk("bnd_exec", alu_en, 1);
    tick(); stop_req = 1;
    tick(); stop_req = 0;
    chk("bnd_ret", retired, 1);

    // 4-bit PC wrap on second instance
    start2 = 1;
    tick(); start2 = 0;
    n = 0;
    while (!(we2 && ret2 == 16'd3) && n < 40) begin n++; tick(); end
    chk("wrap_pre_pc", addr2, 12);
    stop2 = 1;
    tick(); stop2 = 0;
    chk("wrap_pc", addr2, 0);
    chk("wrap_busy", busy2, 0);
    chk("wrap_ret", ret2, 4);

    chk("onehot", onehot_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
